param_sp_ram: RTL and testbench

//   Parametrised single-port synchronous RAM; next generation of the 8x64 single-port RAM.

---
 rtl/param_sp_ram.sv | 109 ++++++++++
 tb/tb_param_sp_ram.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/param_sp_ram.sv
// Parametrised single-port synchronous RAM with byte lanes, selectable
// read-during-write behaviour, optional output register and clear-after-reset.
module param_sp_ram #(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    ADDR_WIDTH     = 6,
    parameter int                    WRITE_MODE     = 0,
    parameter int                    OUT_REG        = 0,
    parameter int                    CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [ADDR_WIDTH-1:0]   adr,
    input  logic [DATA_WIDTH-1:0]   data,
    output logic [DATA_WIDTH-1:0]   q,
    output logic                    q_valid,
    output logic                    busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int LANES = DATA_WIDTH / 8;

    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] READY = 1'b1;

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0] acc_q;
    logic [DATA_WIDTH-1:0] s1_q;
    logic                  acc;
    logic                  acc_v;
    logic                  s1_v;

    assign acc      = !rst && (state == READY) && en;
    assign old_word = mem[adr];

    always_comb begin
        merged = old_word;
        for (int i = 0; i < LANES; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = data[8*i +: 8];
            end
        end
    end

    // NO_CHANGE writes produce no result strobe at all
    assign acc_v = acc && (!we || (WRITE_MODE != 2));
    assign acc_q = (we && (WRITE_MODE == 1)) ? merged : old_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            busy  <= (CLEAR_ON_RESET != 0);
            ptr   <= '0;
        end else if (state == CLEAR) begin
            ptr <= ptr + 1'b1;
            if (ptr == '1) begin
                state <= READY;
                busy  <= 1'b0;
            end
        end
    end

    // The array has no reset; only the sweep and accepted writes touch it
    always_ff @(posedge clk) begin
        if (!rst && (state == CLEAR)) begin
            mem[ptr] <= CLEAR_VALUE;
        end else if (acc && we) begin
            mem[adr] <= merged;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s1_v <= 1'b0;
        end else begin
            s1_v <= acc_v;
            if (acc_v) begin
                s1_q <= acc_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else if (OUT_REG != 0) begin
            q_valid <= s1_v;
            if (s1_v) begin
                q <= s1_q;
            end
        end else begin
            q_valid <= acc_v;
            if (acc_v) begin
                q <= acc_q;
            end
        end
    end

endmodule

// File: tb/tb_param_sp_ram.sv
// Bench for param_sp_ram: three configurations share one stimulus stream
// and are checked every cycle against a word-array model.
module tb_param_sp_ram;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        we;
    logic [1:0]  be;
    logic [5:0]  adr;
    logic [15:0] data;

    logic [7:0]  q0, q2;
    logic [15:0] q1;
    logic        v0, v1, v2;
    logic        b0, b1, b2;

    int n_cmp = 0;
    int n_bad = 0;
    logic armed = 1'b0;

    always #5 clk = ~clk;

    // u0: 8-bit READ_FIRST, u1: 16-bit WRITE_FIRST registered, u2: 8-bit NO_CHANGE
    param_sp_ram #(.DATA_WIDTH(8), .WRITE_MODE(0), .OUT_REG(0)) u0 (
        .clk(clk), .rst(rst), .en(en), .we(we), .be(be[0:0]), .adr(adr),
        .data(data[7:0]), .q(q0), .q_valid(v0), .busy(b0)
    );
    param_sp_ram #(.DATA_WIDTH(16), .WRITE_MODE(1), .OUT_REG(1)) u1 (
        .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .adr(adr),
        .data(data), .q(q1), .q_valid(v1), .busy(b1)
    );
    param_sp_ram #(.DATA_WIDTH(8), .WRITE_MODE(2), .OUT_REG(0)) u2 (
        .clk(clk), .rst(rst), .en(en), .we(we), .be(be[0:0]), .adr(adr),
        .data(data[7:0]), .q(q2), .q_valid(v2), .busy(b2)
    );

    logic [15:0] dq [3];
    logic        dv [3];
    logic        db [3];
    always_comb begin
        dq[0] = {8'h00, q0};
        dq[1] = q1;
        dq[2] = {8'h00, q2};
        dv[0] = v0;
        dv[1] = v1;
        dv[2] = v2;
        db[0] = b0;
        db[1] = b1;
        db[2] = b2;
    end

    // Model: each instance is a 64-word array, a count of clear cycles left,
    // and a delivery line of length 1 or 2 carrying (value, strobe).
    localparam int MODE [3] = '{0, 1, 2};
    localparam int OREG [3] = '{0, 1, 0};

    logic [15:0] mm [3][64];
    int          clr [3] = '{0, 0, 0};
    logic [15:0] eq [3];
    logic        ev [3];
    logic [15:0] pq [3];
    logic        pv [3];
    logic [15:0] old_w, new_w, bm, r_q;
    logic        r_v;

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            r_v = 1'b0;
            r_q = 16'h0;
            if (rst) begin
                clr[k] = 64;
                ev[k] = 1'b0;
                eq[k] = 16'h0;
                pv[k] = 1'b0;
                pq[k] = 16'h0;
            end else if (clr[k] > 0) begin
                mm[k][64 - clr[k]] = 16'h0;
                clr[k] = clr[k] - 1;
                ev[k] = 1'b0;
                pv[k] = 1'b0;
            end else begin
                if (en) begin
                    old_w = mm[k][adr];
                    bm = {(k == 1 && be[1]) ? 8'hFF : 8'h00,
                          be[0] ? 8'hFF : 8'h00};
                    new_w = (old_w & ~bm) | (data & bm);
                    if (we) begin
                        mm[k][adr] = new_w;
                        r_v = (MODE[k] != 2);
                        r_q = (MODE[k] == 1) ? new_w : old_w;
                    end else begin
                        r_v = 1'b1;
                        r_q = old_w;
                    end
                end
                if (OREG[k] != 0) begin
                    ev[k] = pv[k];
                    if (pv[k]) eq[k] = pq[k];
                    pv[k] = r_v;
                    pq[k] = r_q;
                end else begin
                    ev[k] = r_v;
                    if (r_v) eq[k] = r_q;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("busy[u%0d]", k), {15'h0, db[k]},
                    {15'h0, clr[k] > 0});
                chk($sformatf("q_valid[u%0d]", k), {15'h0, dv[k]},
                    {15'h0, ev[k]});
                chk($sformatf("q[u%0d]", k), dq[k], eq[k]);
            end
        end
    end

    task automatic step(input logic e, input logic w, input logic [1:0] b,
                        input logic [5:0] a, input logic [15:0] d);
        en   = e;
        we   = w;
        be   = b;
        adr  = a;
        data = d;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 2'b00, 6'd0, 16'h0);
    endtask

    // Counts busy cycles while hammering a write to 7 that must be ignored
    task automatic count_busy(input string nm);
        int n;
        n = 0;
        while (b0 && n < 200) begin
            n++;
            step(1'b1, 1'b1, 2'b11, 6'd7, 16'h5555);
        end
        chk(nm, 16'(n), 16'd64);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        rst = 1'b0;
        armed = 1'b1;
        chk("busy_after_reset", {15'h0, b0}, 16'h1);
        chk("q_after_reset", q1, 16'h0);
        count_busy("busy_cycles_first");

        for (int i = 0; i < 64; i++) begin
            step(1'b1, 1'b0, 2'b00, 6'(i), 16'h0);
        end
        chk("cleared_q63", {8'h0, q0}, 16'h0);
        chk("cleared_v63", {15'h0, v0}, 16'h1);
        step(1'b1, 1'b0, 2'b00, 6'd7, 16'h0);
        chk("ignored_write_7", {8'h0, q0}, 16'h0);

        step(1'b1, 1'b1, 2'b11, 6'd0, 16'h0001);
        step(1'b1, 1'b1, 2'b11, 6'd1, 16'h0002);
        step(1'b1, 1'b1, 2'b11, 6'd2, 16'h0003);
        step(1'b1, 1'b1, 2'b00, 6'd0, 16'hFFFF);
        step(1'b1, 1'b0, 2'b00, 6'd0, 16'h0);
        chk("rd0", {8'h0, q0}, 16'h0001);
        step(1'b1, 1'b0, 2'b00, 6'd1, 16'h0);
        chk("rd1", {8'h0, q0}, 16'h0002);
        step(1'b1, 1'b0, 2'b00, 6'd2, 16'h0);
        chk("rd2", {8'h0, q0}, 16'h0003);
        idle();
        chk("hold_q", {8'h0, q0}, 16'h0003);
        chk("hold_v", {15'h0, v0}, 16'h0);

        step(1'b1, 1'b0, 2'b00, 6'd2, 16'h0);
        chk("oreg_lat1_v", {15'h0, v1}, 16'h0);
        idle();
        chk("oreg_lat2_v", {15'h0, v1}, 16'h1);
        chk("oreg_lat2_q", q1, 16'h0003);
        idle();
        chk("oreg_lat3_v", {15'h0, v1}, 16'h0);

        step(1'b1, 1'b1, 2'b11, 6'd5, 16'hAABB);
        step(1'b1, 1'b1, 2'b01, 6'd5, 16'h1234);
        step(1'b1, 1'b0, 2'b00, 6'd5, 16'h0);
        chk("lane8_rd5", {8'h0, q0}, 16'h0034);
        idle();
        chk("lane16_rd5", q1, 16'hAA34);
        idle();

        step(1'b1, 1'b1, 2'b11, 6'd1, 16'h0004);
        idle();
        idle();
        step(1'b1, 1'b1, 2'b11, 6'd1, 16'h0009);
        chk("rf_q", {8'h0, q0}, 16'h0004);
        chk("rf_v", {15'h0, v0}, 16'h1);
        chk("nc_v", {15'h0, v2}, 16'h0);
        chk("nc_q", {8'h0, q2}, 16'h0034);
        idle();
        chk("wf_q", q1, 16'h0009);
        step(1'b1, 1'b0, 2'b00, 6'd1, 16'h0);
        chk("rd1_after", {8'h0, q0}, 16'h0009);
        idle();
        idle();

        step(1'b1, 1'b0, 2'b00, 6'd3, 16'h0);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        chk("drop_inflight_v", {15'h0, v1}, 16'h0);
        for (int i = 0; i < 30; i++) idle();
        rst = 1'b1;
        idle();
        rst = 1'b0;
        count_busy("busy_cycles_restart");
        step(1'b1, 1'b0, 2'b00, 6'd1, 16'h0);
        chk("recleared_1", {8'h0, q0}, 16'h0);
        idle();
        idle();

        armed = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
